systolic_skew_feeder: RTL and testbench

Edge feeder for the systolic array: accepts operand row-vectors over a valid/ready stream, buffers one tile, then drains it onto the array's west edge with a diagonal skew (lane i delayed i steps), so each row of MAC cells receives its operands on the correct wavefront. Sits directly upstream of the MAC row inputs; one instance per array edge (A and B operands).

---
 rtl/systolic_pkg.sv | 39 +++
 rtl/skew_bank.sv | 48 ++++
 rtl/systolic_skew_feeder.sv | 207 ++++++++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared types and sizing helpers for the systolic array edge feeders and the
// MAC array top.
//   feeder_state_t : edge feeder FSM encoding (FILL, DRAIN)
//   count_width()  : width of the feeder vector/step counters
//   slot_width()   : width of a tile slot index (never below 1)
//   lane_lsb()     : LSB position of a lane inside a packed lane vector
// -----------------------------------------------------------------------------
package systolic_pkg;

   typedef enum logic [0:0] {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } feeder_state_t;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_LANES      = 4;
   localparam int DEFAULT_DEPTH      = 4;

   // Step counter must hold the terminal step DEPTH+LANES-2 and the vector
   // count DEPTH without wrapping.
   function automatic int count_width(input int depth, input int lanes);
      int w;
      w = $clog2(depth + lanes);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int slot_width(input int depth);
      int w;
      w = $clog2(depth);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/skew_bank.sv
// -----------------------------------------------------------------------------
// skew_bank
// One tile of storage: DEPTH slots, each holding a full LANES-wide vector.
// Whole vectors are written through a single port; every lane is read from
// its own slot index so the drain can present a diagonal wavefront.
// No reset on the storage: slot contents are only consumed when the feeder
// marks them live.
// Ports:
//   clk_i    : clock
//   we_i     : write enable for slot waddr_i
//   waddr_i  : write slot index
//   wdata_i  : vector to store, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   raddr_i  : per-lane read slot index, lane i at [i*SW +: SW]
//   rdata_o  : lane i of slot raddr_i[lane i], packed like wdata_i
// -----------------------------------------------------------------------------
module skew_bank
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int LANES      = DEFAULT_LANES,
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int SW         = slot_width(DEFAULT_DEPTH)
) (
   input  logic                        clk_i,
   input  logic                        we_i,
   input  logic [SW-1:0]               waddr_i,
   input  logic [LANES*DATA_WIDTH-1:0] wdata_i,
   input  logic [LANES*SW-1:0]         raddr_i,
   output logic [LANES*DATA_WIDTH-1:0] rdata_o
);

   logic [LANES*DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_comb begin
      rdata_o = '0;
      for (int i = 0; i < LANES; i++) begin
         rdata_o[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] =
            mem_q[raddr_i[i*SW +: SW]][lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
      end
   end

endmodule

// File: rtl/systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder
// West-edge operand feeder for the systolic array. Collects up to DEPTH
// row-vectors into a tile, then drains the tile with lane i delayed i steps so
// each MAC row sees its operands on the right wavefront.
//
// Optional feature macro: SKEW_FEEDER_DOUBLE_BUFFER_EN
//   defined   : two ping-pong banks; filling continues while the other bank
//               drains and a closed bank starts draining with no bubble.
//   undefined : one bank; input is blocked for the whole drain.
//
// Handshake: a vector transfers on a rising clk edge where in_valid and
// in_ready are both high; in_last is only meaningful on that edge. On the
// output side out_ready is an advance enable: when high the registered
// outputs load the next step (or zeros when nothing is draining), when low
// out_data/out_valid hold. tile_done is a single-cycle pulse.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    : upstream vector valid
//   in_ready    : feeder accepts a vector this cycle
//   in_data     : vector, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_last     : closes the current tile
//   out_ready   : array advance enable
//   out_data    : skewed lane data, same packing as in_data
//   out_valid   : per-lane element valid
//   tile_done   : pulse coincident with the final drain step
//   dbg_state   : current FSM state
// -----------------------------------------------------------------------------
module systolic_skew_feeder
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int LANES      = DEFAULT_LANES,
   parameter int DEPTH      = DEFAULT_DEPTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [LANES*DATA_WIDTH-1:0] in_data,
   input  logic                        in_last,
   input  logic                        out_ready,
   output logic [LANES*DATA_WIDTH-1:0] out_data,
   output logic [LANES-1:0]            out_valid,
   output logic                        tile_done,
   output feeder_state_t               dbg_state
);

   localparam int CW = count_width(DEPTH, LANES);
   localparam int SW = slot_width(DEPTH);

`ifdef SKEW_FEEDER_DOUBLE_BUFFER_EN
   localparam int NB = 2;
`else
   localparam int NB = 1;
`endif

   // Banks are used strictly in rotation; with a single bank the selector
   // stays at 0.
   function automatic logic next_sel(input logic sel);
      return (NB == 2) ? ~sel : 1'b0;
   endfunction

   feeder_state_t               state_q, state_d;
   logic [CW-1:0]               cnt_q [NB];
   logic [CW-1:0]               cnt_d [NB];
   logic                        closed_q [NB];
   logic                        closed_d [NB];
   logic                        fill_sel_q, fill_sel_d;
   logic                        drain_sel_q, drain_sel_d;
   logic [CW-1:0]               t_q, t_d;
   logic [LANES*DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [LANES-1:0]            out_valid_q, out_valid_d;
   logic                        tile_done_q, tile_done_d;

   logic                        hs;
   logic [CW-1:0]               n_drain;
   logic                        last_step;
   logic [LANES-1:0]            lane_live;
   logic [LANES*SW-1:0]         rd_idx;
   logic [LANES*DATA_WIDTH-1:0] rd_data [NB];
   logic [NB-1:0]               bank_we;

   // A closed bank refuses input until its drain completes, which also covers
   // the single-bank case where FILL/DRAIN map directly to open/closed.
   assign in_ready  = ~rst & ~closed_q[fill_sel_q];
   assign hs        = in_valid & in_ready;
   assign n_drain   = cnt_q[drain_sel_q];
   assign last_step = (int'(t_q) == int'(n_drain) + LANES - 2);

   // Lane i carries slot t-i while that slot exists in the tile.
   always_comb begin
      lane_live = '0;
      rd_idx    = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_live[i] = (int'(t_q) >= i) && ((int'(t_q) - i) < int'(n_drain));
         if (lane_live[i]) begin
            rd_idx[i*SW +: SW] = SW'(int'(t_q) - i);
         end
      end
   end

   for (genvar b = 0; b < NB; b++) begin : g_bank
      assign bank_we[b] = hs && (int'(fill_sel_q) == b);

      skew_bank #(
         .DATA_WIDTH (DATA_WIDTH),
         .LANES      (LANES),
         .DEPTH      (DEPTH),
         .SW         (SW)
      ) u_bank (
         .clk_i   (clk),
         .we_i    (bank_we[b]),
         .waddr_i (cnt_q[b][SW-1:0]),
         .wdata_i (in_data),
         .raddr_i (rd_idx),
         .rdata_o (rd_data[b])
      );
   end

   always_comb begin
      state_d     = state_q;
      t_d         = t_q;
      fill_sel_d  = fill_sel_q;
      drain_sel_d = drain_sel_q;
      for (int b = 0; b < NB; b++) begin
         cnt_d[b]    = cnt_q[b];
         closed_d[b] = closed_q[b];
      end
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      tile_done_d = 1'b0;

      // Fill side: the tile closes on in_last or when the last slot is used.
      if (hs) begin
         cnt_d[fill_sel_q] = cnt_q[fill_sel_q] + CW'(1);
         if (in_last || (int'(cnt_q[fill_sel_q]) == DEPTH - 1)) begin
            closed_d[fill_sel_q] = 1'b1;
            fill_sel_d           = next_sel(fill_sel_q);
         end
      end

      // Drain side: only advances on out_ready.
      if (out_ready) begin
         if (state_q == DRAIN) begin
            for (int i = 0; i < LANES; i++) begin
               out_valid_d[i] = lane_live[i];
               out_data_d[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = lane_live[i] ?
                  rd_data[drain_sel_q][lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] : '0;
            end
            if (last_step) begin
               tile_done_d           = 1'b1;
               t_d                   = '0;
               cnt_d[drain_sel_q]    = '0;
               closed_d[drain_sel_q] = 1'b0;
               drain_sel_d           = next_sel(drain_sel_q);
            end else begin
               t_d = t_q + CW'(1);
            end
         end else begin
            out_data_d  = '0;
            out_valid_d = '0;
         end
      end

      // Drain whenever the bank next in line is closed (or closing this edge);
      // this is what removes the bubble in the ping-pong build.
      if (state_q == FILL || (out_ready && last_step)) begin
         state_d = closed_d[drain_sel_d] ? DRAIN : FILL;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FILL;
         t_q         <= '0;
         fill_sel_q  <= 1'b0;
         drain_sel_q <= 1'b0;
         for (int b = 0; b < NB; b++) begin
            cnt_q[b]    <= '0;
            closed_q[b] <= 1'b0;
         end
         out_data_q  <= '0;
         out_valid_q <= '0;
         tile_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         t_q         <= t_d;
         fill_sel_q  <= fill_sel_d;
         drain_sel_q <= drain_sel_d;
         for (int b = 0; b < NB; b++) begin
            cnt_q[b]    <= cnt_d[b];
            closed_q[b] <= closed_d[b];
         end
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         tile_done_q <= tile_done_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign tile_done = tile_done_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_skew_feeder
// Directed bench for systolic_skew_feeder (LANES=4, DEPTH=4, DATA_WIDTH=32).
// Vector v of a tile with base b carries lane i = b + 0x10*v + i, so every
// drained element identifies its slot and lane.
// -----------------------------------------------------------------------------
module tb_systolic_skew_feeder;
   import systolic_pkg::*;

   localparam int DW    = 32;
   localparam int LANES = 4;
   localparam int DEPTH = 4;
   localparam int W     = LANES * DW;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    in_data;
   logic            in_last;
   logic            out_ready;
   logic [W-1:0]    out_data;
   logic [LANES-1:0] out_valid;
   logic            tile_done;
   feeder_state_t   dbg_state;

   int vectors     = 0;
   int miscompares = 0;

   systolic_skew_feeder #(
      .DATA_WIDTH (DW),
      .LANES      (LANES),
      .DEPTH      (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .tile_done (tile_done),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] vec(input int base, input int v);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < LANES; i++) r[i*DW +: DW] = DW'(base + 16 * v + i);
      return r;
   endfunction

   function automatic logic [LANES-1:0] exp_valid(input int n, input int t);
      logic [LANES-1:0] r;
      r = '0;
      for (int i = 0; i < LANES; i++) r[i] = (t >= i) && (t < i + n);
      return r;
   endfunction

   function automatic logic [W-1:0] exp_data(input int base, input int n, input int t);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < LANES; i++)
         if (t >= i && t < i + n) r[i*DW +: DW] = DW'(base + 16 * (t - i) + i);
      return r;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic send_tile(input int base, input int n, input bit use_last);
      for (int v = 0; v < n; v++) begin
         in_valid = 1'b1;
         in_data  = vec(base, v);
         in_last  = use_last && (v == n - 1);
         tick();
         chk("fill_out_valid", W'(out_valid), '0);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_step(input int base, input int n, input int t);
      int last;
      last = n + LANES - 2;
      chk($sformatf("valid_t%0d", t), W'(out_valid), W'(exp_valid(n, t)));
      chk($sformatf("data_t%0d", t), out_data, exp_data(base, n, t));
      chk($sformatf("done_t%0d", t), W'(tile_done), W'(t == last));
`ifndef SKEW_FEEDER_DOUBLE_BUFFER_EN
      chk($sformatf("ready_t%0d", t), W'(in_ready), W'(t == last));
`endif
   endtask

   // Drains one tile; optional 3-cycle out_ready stall after step stall_at.
   task automatic drain(input int base, input int n, input int stall_at);
      for (int t = 0; t <= n + LANES - 2; t++) begin
         tick();
         check_step(base, n, t);
         if (t == stall_at) begin
            out_ready = 1'b0;
            repeat (3) begin
               tick();
               chk("hold_valid", W'(out_valid), W'(exp_valid(n, t)));
               chk("hold_data", out_data, exp_data(base, n, t));
               chk("hold_done", W'(tile_done), '0);
            end
            out_ready = 1'b1;
         end
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;

      // Reset state
      tick();
      chk("rst_in_ready", W'(in_ready), '0);
      tick();
      chk("rst_out_valid", W'(out_valid), '0);
      chk("rst_out_data", out_data, '0);
      chk("rst_tile_done", W'(tile_done), '0);
      chk("rst_state", W'(dbg_state), W'(FILL));
      rst = 1'b0;
      #1;
      chk("post_rst_ready", W'(in_ready), W'(1));

      // Full tile closed by DEPTH, 7 steps
      send_tile(32'h00, 4, 1'b0);
      chk("drain_state", W'(dbg_state), W'(DRAIN));
      drain(32'h00, 4, -1);
      chk("t1_step6_lane3", out_data, {32'h33, 96'h0});

      // Two-vector tile closed by in_last, 5 steps
      send_tile(32'h50, 2, 1'b1);
      drain(32'h50, 2, -1);
      tick();
      chk("idle_valid", W'(out_valid), '0);
      chk("idle_data", out_data, '0);

      // Stall mid-drain: outputs hold, step sequence unchanged
      send_tile(32'h20, 4, 1'b1);
      drain(32'h20, 4, 2);

`ifndef SKEW_FEEDER_DOUBLE_BUFFER_EN
      // in_valid held during drain: nothing taken until FILL
      send_tile(32'h60, 3, 1'b1);
      in_valid = 1'b1;
      in_data  = vec(32'hA0, 0);
      drain(32'h60, 3, -1);
      tick();
      chk("held_accept_valid", W'(out_valid), '0);
      in_data = vec(32'hA0, 1);
      in_last = 1'b1;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("held_close_ready", W'(in_ready), '0);
      drain(32'hA0, 2, -1);
`endif

      // Reset pulsed at drain step 2
      send_tile(32'h70, 4, 1'b1);
      for (int t = 0; t <= 2; t++) begin
         tick();
         check_step(32'h70, 4, t);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("midrst_valid", W'(out_valid), '0);
      chk("midrst_data", out_data, '0);
      chk("midrst_done", W'(tile_done), '0);
      chk("midrst_ready", W'(in_ready), W'(1));
      send_tile(32'h40, 3, 1'b1);
      drain(32'h40, 3, -1);

`ifdef SKEW_FEEDER_DOUBLE_BUFFER_EN
      // Back-to-back full tiles: B fills while A drains, no bubble between
      send_tile(32'h00, 4, 1'b0);
      for (int c = 0; c < 14; c++) begin
         in_valid = (c < 4);
         in_data  = vec(32'h80, c);
         in_last  = 1'b0;
         tick();
         if (c < 7) begin
            chk("db_a_valid", W'(out_valid), W'(exp_valid(4, c)));
            chk("db_a_data", out_data, exp_data(32'h00, 4, c));
            chk("db_a_done", W'(tile_done), W'(c == 6));
         end else begin
            chk("db_b_valid", W'(out_valid), W'(exp_valid(4, c - 7)));
            chk("db_b_data", out_data, exp_data(32'h80, 4, c - 7));
            chk("db_b_done", W'(tile_done), W'(c == 13));
         end
         chk("db_ready", W'(in_ready), W'(c < 3 || c >= 6));
      end
      in_valid = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
